load_store_unit: RTL

//  Data-memory access stage fed by the control FSM during MEMADR/MEMREAD/MEMWRITE.

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit_align.sv | 66 ++++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
// Rev 1.0 - initial release
`default_nettype none

package load_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'b00,
    FAULT_MISALIGNED = 2'b01,
    FAULT_TIMEOUT    = 2'b10,
    FAULT_ILLEGAL    = 2'b11
  } lsu_fault_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Loads accept the unsigned byte/half forms; stores only B/H/W.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Rev 1.0 - initial release
`default_nettype none

interface load_store_unit_if #(
  parameter int XLEN = 32
) ();
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_be;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store byte enables/replication, load extract/extend, access checks.
// Rev 1.0 - initial release
`default_nettype none

module load_store_unit_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      store_be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_ext,
  output logic            illegal,
  output logic            misaligned
);

  logic [XLEN-1:0] lane;

  always_comb begin
    store_be = 4'b0000;
    case (funct3)
      F3_B:    store_be = 4'b0001 << addr_lo;
      F3_H:    store_be = 4'b0011 << {addr_lo[1], 1'b0};
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  always_comb begin
    wdata = store_data;
    case (funct3[1:0])
      2'b00:   wdata = {(XLEN/8){store_data[7:0]}};
      2'b01:   wdata = {(XLEN/16){store_data[15:0]}};
      default: wdata = store_data;
    endcase
  end

  // Extraction uses the latched access so it lines up with bus_rdata at ack time.
  always_comb begin
    lane     = rdata >> {ld_addr_lo, 3'b000};
    load_ext = lane;
    case (ld_funct3)
      F3_B:    load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_BU:   load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_H:    load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_HU:   load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    illegal    = !funct3_legal(funct3, is_store);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// Data-memory access stage: request FSM with bus timeout, result and status registers.
// Rev 1.0 - initial release
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_load,
  input  logic                start_store,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     addr,
  input  logic [XLEN-1:0]     store_data,
  output logic [3:0]          byte_en,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     load_data,
  output logic                fault,
  output logic [1:0]          fault_cause,
  load_store_unit_if.master   bus
);

  localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES);

  lsu_state_t      state;
  logic [TW-1:0]   timer;
  logic [2:0]      req_funct3;
  logic [1:0]      req_addr_lo;

  logic            start;
  logic            is_store;
  logic [3:0]      store_be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] load_ext;
  logic            illegal;
  logic            misaligned;

  assign start    = start_load | start_store;
  assign is_store = start_store & ~start_load;
  // A load pulse means the enables are not destined for a write.
  assign byte_en  = start_load ? 4'b0000 : store_be;
  assign busy     = (state != IDLE);

  load_store_unit_align #(.XLEN(XLEN)) u_align (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .is_store   (is_store),
    .store_data (store_data),
    .ld_funct3  (req_funct3),
    .ld_addr_lo (req_addr_lo),
    .rdata      (bus.bus_rdata),
    .store_be   (store_be),
    .wdata      (wdata),
    .load_ext   (load_ext),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      req_funct3    <= 3'b000;
      req_addr_lo   <= 2'b00;
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_cause   <= FAULT_NONE;
      load_data     <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              state       <= DONE;
              done        <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= FAULT_ILLEGAL;
            end else if (misaligned) begin
              state       <= DONE;
              done        <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= FAULT_MISALIGNED;
            end else begin
              state         <= REQ;
              timer         <= TW'(1);
              req_funct3    <= funct3;
              req_addr_lo   <= addr[1:0];
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= is_store;
              bus.bus_addr  <= {addr[XLEN-1:2], 2'b00};
              bus.bus_wdata <= wdata;
              bus.bus_be    <= is_store ? store_be : 4'b0000;
            end
          end
        end
        REQ: begin
          // Ack is checked first so an ack on the final cycle still succeeds.
          if (bus.bus_ack) begin
            state       <= DONE;
            done        <= 1'b1;
            fault       <= 1'b0;
            fault_cause <= FAULT_NONE;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            if (!bus.bus_we) load_data <= load_ext;
          end else if (timer == TIMER_LAST) begin
            state       <= DONE;
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= FAULT_TIMEOUT;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
